// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared fetch-stage types: instruction field positions, reset
//                PC default, fetch FSM states and FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int c_OP_MSB    = 31;
    localparam int c_OP_LSB    = 26;
    localparam int c_FUNCT_MSB = 5;
    localparam int c_FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory, redirect and decode handshakes of the
//                fetch stage. master = fetch unit, slave = memory/decode side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  op;
    logic [5:0]  funct;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, pc_plus4, op, funct,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, pc_plus4, op, funct,
        output instr_ready
    );

endinterface

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// ============================================================================
//  Module      : fetch_fifo
//  Description : Synchronous instruction buffer with push/pop/flush and a
//                registered head that holds its last value when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_ONE_CNT   = c_CNT_W'(1);

    fetch_entry_t        r_mem [DEPTH];
    fetch_entry_t        r_head;
    fetch_entry_t        w_head_next;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  w_rd_ptr_inc;
    logic [c_CNT_W-1:0]  r_count;
    logic                w_do_pop;
    logic                w_do_push;

    assign w_do_pop     = pop && (r_count != '0);
    assign w_do_push    = push && ((r_count < c_DEPTH_CNT) || w_do_pop);
    assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

    // The head register always mirrors the oldest live entry after the edge.
    always_comb begin
        w_head_next = r_head;
        if (w_do_pop) begin
            if (r_count > c_ONE_CNT) begin
                w_head_next = r_mem[w_rd_ptr_inc];
            end else if (w_do_push) begin
                w_head_next = push_data;
            end
        end else if ((r_count == '0) && w_do_push) begin
            w_head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_ONE_CNT;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - c_ONE_CNT;
            end
            r_head <= w_head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head       = r_head;
    assign head_valid = (r_count != '0);
    assign count      = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage: PC, imem req/ack, instruction FIFO
//                and redirect flush. Optional FETCH_STALL_CNT_EN adds stall_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = c_RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       bus
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(FIFO_DEPTH);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [31:0]         r_fetch_pc;
    logic [31:0]         r_drop_addr;
    logic                w_req;
    logic [31:0]         w_addr;
    logic                w_push;
    logic                w_accept;
    fetch_entry_t        w_push_data;
    fetch_entry_t        w_head;
    logic                w_head_valid;
    logic [c_CNT_W-1:0]  w_count;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_addr       = r_fetch_pc;
        case (r_state)
            ST_RST: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                w_req = (w_count < c_DEPTH_CNT);
                // A redirect with the read still in flight must wait out the ack.
                if (bus.redirect_valid && w_req && !bus.imem_ack) begin
                    w_state_next = ST_DROP;
                end
            end
            ST_DROP: begin
                w_req  = 1'b1;
                w_addr = r_drop_addr;
                if (bus.imem_ack) begin
                    w_state_next = ST_FETCH;
                end
            end
            default: begin
                w_state_next = ST_RST;
            end
        endcase
    end

    assign w_accept    = (r_state == ST_FETCH) && w_req && bus.imem_ack;
    assign w_push      = w_accept && !bus.redirect_valid;
    assign w_push_data = '{pc: r_fetch_pc, instr: bus.imem_rdata};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RST;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state <= w_state_next;
            if (bus.redirect_valid) begin
                r_fetch_pc <= word_align(bus.redirect_pc);
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            // Only consulted in DROP, so capturing on every FETCH cycle is enough.
            if (r_state == ST_FETCH) begin
                r_drop_addr <= r_fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_data  (w_push_data),
        .pop        (bus.instr_ready),
        .flush      (bus.redirect_valid),
        .head       (w_head),
        .head_valid (w_head_valid),
        .count      (w_count)
    );

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = w_addr;
    assign bus.instr_valid = w_head_valid;
    assign bus.instr       = w_head.instr;
    assign bus.instr_pc    = w_head.pc;
    assign bus.pc_plus4    = w_head.pc + 32'd4;
    assign bus.op          = w_head.instr[c_OP_MSB:c_OP_LSB];
    assign bus.funct       = w_head.instr[c_FUNCT_MSB:c_FUNCT_LSB];

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (bus.instr_ready && !w_head_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit (directed tables, corner
//                sequences and randomized traffic against a stream model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_unit_if bus();
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        ack;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] hashw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic idle_inputs();
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    32'(bus.imem_req),    32'h0);
        check({tag, "_addr"},   bus.imem_addr,        32'h0);
        check({tag, "_valid"},  32'(bus.instr_valid), 32'h0);
        check({tag, "_instr"},  bus.instr,            32'h0);
        check({tag, "_pc"},     bus.instr_pc,         32'h0);
        check({tag, "_plus4"},  bus.pc_plus4,         32'h4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        logic [31:0] w;
        logic [31:0] exp_pc;
        int          acks;
        int          pops;
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic        redir_last;
        logic        redir;
        logic [31:0] rp;

        // ---------------- 1: streaming fetch, table driven ----------------
        tbl[0] = '{ack:1'b1, ready:1'b1, exp_req:1'b0, exp_addr:32'h0,  exp_valid:1'b0, exp_pc:32'h0};
        tbl[1] = '{ack:1'b1, ready:1'b1, exp_req:1'b1, exp_addr:32'h0,  exp_valid:1'b0, exp_pc:32'h0};
        tbl[2] = '{ack:1'b1, ready:1'b1, exp_req:1'b1, exp_addr:32'h4,  exp_valid:1'b1, exp_pc:32'h0};
        tbl[3] = '{ack:1'b1, ready:1'b1, exp_req:1'b1, exp_addr:32'h8,  exp_valid:1'b1, exp_pc:32'h4};
        tbl[4] = '{ack:1'b1, ready:1'b1, exp_req:1'b1, exp_addr:32'hC,  exp_valid:1'b1, exp_pc:32'h8};
        tbl[5] = '{ack:1'b1, ready:1'b1, exp_req:1'b1, exp_addr:32'h10, exp_valid:1'b1, exp_pc:32'hC};

        do_reset();
        check_reset_outputs("reset");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_req[%0d]", i),   32'(bus.imem_req),    32'(tbl[i].exp_req));
            check($sformatf("t1_addr[%0d]", i),  bus.imem_addr,        tbl[i].exp_addr);
            check($sformatf("t1_valid[%0d]", i), 32'(bus.instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                w = pat(tbl[i].exp_pc);
                check($sformatf("t1_pc[%0d]", i),    bus.instr_pc, tbl[i].exp_pc);
                check($sformatf("t1_instr[%0d]", i), bus.instr,    w);
                check($sformatf("t1_op[%0d]", i),    32'(bus.op),    32'(w[31:26]));
                check($sformatf("t1_funct[%0d]", i), 32'(bus.funct), 32'(w[5:0]));
                check($sformatf("t1_plus4[%0d]", i), bus.pc_plus4, tbl[i].exp_pc + 32'd4);
            end
            bus.instr_ready = tbl[i].ready;
            bus.imem_ack    = tbl[i].ack && bus.imem_req;
            bus.imem_rdata  = pat(bus.imem_addr);
            tick();
        end

        // ---------------- 2: backpressure fills the buffer ----------------
        do_reset();
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = pat(bus.imem_addr);
            if (bus.imem_req) acks++;
            tick();
        end
        bus.imem_ack = 1'b0;
        check("t2_acks",  32'(acks),            32'd2);
        check("t2_req",   32'(bus.imem_req),    32'h0);
        check("t2_valid", 32'(bus.instr_valid), 32'h1);
        check("t2_head",  bus.instr_pc,         32'h0);
        bus.instr_ready = 1'b1;
        exp_pc = 32'h0;
        pops   = 0;
        for (int i = 0; i < 30 && pops < 6; i++) begin
            if (bus.instr_valid) begin
                check("t2_order", bus.instr_pc, exp_pc);
                exp_pc += 32'd4;
                pops++;
            end
            bus.imem_ack   = bus.imem_req;
            bus.imem_rdata = pat(bus.imem_addr);
            tick();
        end
        check("t2_pops", 32'(pops), 32'd6);

        // ---------------- 3: redirect with request pending ----------------
        do_reset();
        bus.instr_ready = 1'b1;
        tick();
        check("t3_req0",  32'(bus.imem_req), 32'h1);
        check("t3_addr0", bus.imem_addr,     32'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_hold_req[%0d]", i),  32'(bus.imem_req),    32'h1);
            check($sformatf("t3_hold_addr[%0d]", i), bus.imem_addr,        32'h0);
            check($sformatf("t3_hold_vld[%0d]", i),  32'(bus.instr_valid), 32'h0);
            if (i == 2) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = pat(32'h0);
            end
            tick();
        end
        check("t3_new_req",  32'(bus.imem_req),    32'h1);
        check("t3_new_addr", bus.imem_addr,        32'h100);
        check("t3_dropped",  32'(bus.instr_valid), 32'h0);
        bus.imem_rdata = pat(32'h100);
        tick();
        bus.imem_ack = 1'b0;
        check("t3_vld",   32'(bus.instr_valid), 32'h1);
        check("t3_pc",    bus.instr_pc,         32'h100);
        check("t3_instr", bus.instr,            pat(32'h100));

        // ------- 4: redirect coincident with ack and pop, unaligned pc -------
        do_reset();
        bus.instr_ready = 1'b1;
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = pat(32'h0);
        tick();
        check("t4_vld_pre",  32'(bus.instr_valid), 32'h1);
        check("t4_addr_pre", bus.imem_addr,        32'h4);
        bus.imem_rdata     = pat(32'h4);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        tick();
        bus.redirect_valid = 1'b0;
        check("t4_flush", 32'(bus.instr_valid), 32'h0);
        check("t4_req",   32'(bus.imem_req),    32'h1);
        check("t4_addr",  bus.imem_addr,        32'h100);
        bus.imem_rdata = pat(32'h100);
        tick();
        bus.imem_ack = 1'b0;
        check("t4_vld", 32'(bus.instr_valid), 32'h1);
        check("t4_pc",  bus.instr_pc,         32'h100);

        // ---------------- 5: reset mid-request ----------------
        do_reset();
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = pat(32'h0);
        tick();
        bus.imem_ack = 1'b0;
        check("t5_pre_vld", 32'(bus.instr_valid), 32'h1);
        check("t5_pre_req", 32'(bus.imem_req),    32'h1);
        reset          = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = pat(32'h4);
        tick();
        tick();
        check_reset_outputs("t5_inrst");
        reset        = 1'b0;
        bus.imem_ack = 1'b0;
        check("t5_rst_req", 32'(bus.imem_req), 32'h0);
        tick();
        check("t5_first_req",  32'(bus.imem_req), 32'h1);
        check("t5_first_addr", bus.imem_addr,     32'h0);

`ifdef FETCH_STALL_CNT_EN
        // ---------------- 6: stall counter ----------------
        do_reset();
        bus.instr_ready = 1'b1;
        tick();
        tick();
        rp = stall_cnt;
        for (int i = 0; i < 5; i++) tick();
        check("t6_stall", stall_cnt - rp, 32'd5);
`endif

        // ---------------- random traffic vs stream model ----------------
        do_reset();
        exp_pc     = 32'h0;
        pops       = 0;
        prev_pend  = 1'b0;
        prev_addr  = 32'h0;
        redir_last = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (prev_pend) begin
                check("rnd_req_hold",  32'(bus.imem_req), 32'h1);
                check("rnd_addr_hold", bus.imem_addr,     prev_addr);
            end
            if (redir_last) check("rnd_flush", 32'(bus.instr_valid), 32'h0);
            check("rnd_align", 32'(bus.imem_addr[1:0]), 32'h0);
            if (bus.instr_valid) begin
                w = hashw(bus.instr_pc);
                check("rnd_instr", bus.instr,    w);
                check("rnd_op",    32'(bus.op),    32'(w[31:26]));
                check("rnd_funct", 32'(bus.funct), 32'(w[5:0]));
                check("rnd_plus4", bus.pc_plus4, bus.instr_pc + 32'd4);
            end
            redir = ($urandom % 20) == 0;
            if ($urandom % 8 == 0) rp = 32'hFFFF_FFF0 | 32'($urandom % 16);
            else                   rp = 32'($urandom_range(0, 1023));
            bus.redirect_valid = redir;
            bus.redirect_pc    = rp;
            bus.instr_ready    = ($urandom % 4) != 0;
            bus.imem_ack       = bus.imem_req && (($urandom % 2) == 0);
            bus.imem_rdata     = hashw(bus.imem_addr);
            if (redir) begin
                exp_pc = {rp[31:2], 2'b00};
            end else if (bus.instr_valid && bus.instr_ready) begin
                check("rnd_stream_pc", bus.instr_pc, exp_pc);
                exp_pc += 32'd4;
                pops++;
            end
            prev_pend  = bus.imem_req && !bus.imem_ack;
            prev_addr  = bus.imem_addr;
            redir_last = redir;
            tick();
        end
        idle_inputs();
        check("rnd_progress", 32'(pops > 300), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
